// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants, coordinate type and total-period helpers
// shared by the timing generator and its delay line.
package vga_timing_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  // Levels driven whenever the raster is not producing a live timing pulse.
  localparam logic HS_INACTIVE    = 1'b1;
  localparam logic VS_INACTIVE    = 1'b1;
  localparam logic BLANK_INACTIVE = 1'b0;

  typedef logic [9:0] coord_t;

  function automatic int unsigned h_total(input int unsigned vis, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned vis, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register; reset flushes every stage to RESET_VAL and forces
// the output to RESET_VAL while held. DEPTH=0 is a (reset-gated) passthrough.
module vga_delay_line #(
  parameter int unsigned         WIDTH     = 1,
  parameter int unsigned         DEPTH     = 1,
  parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  if (DEPTH == 0) begin : g_pass
    assign delayed = reset ? RESET_VAL : data;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge vga_clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
        stage[0] <= data;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign delayed = reset ? RESET_VAL : stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, sync/blank decode re-aligned by PIPE_DELAY to the renderer
// colour latency, line/frame strobes and a free-running frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  output coord_t     DrawX,
  output coord_t     DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIPE_DELAY > 4) begin : g_bad_params
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024 and PIPE_DELAY <= 4");
  end

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly.
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t      hc;
  coord_t      vc;
  logic [7:0]  frames;
  logic        h_wrap;
  logic        v_wrap;

  assign h_wrap = (hc == H_LAST);
  assign v_wrap = (vc == V_LAST);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc     <= '0;
      vc     <= '0;
      frames <= '0;
    end else if (h_wrap) begin
      hc <= '0;
      if (v_wrap) begin
        vc     <= '0;
        frames <= frames + 8'd1;
      end else begin
        vc <= vc + 10'd1;
      end
    end else begin
      hc <= hc + 10'd1;
    end
  end

  logic [10:0] hx;
  logic [10:0] vy;
  logic        hs_raw;
  logic        vs_raw;
  logic        blank_raw;

  assign hx        = {1'b0, hc};
  assign vy        = {1'b0, vc};
  assign hs_raw    = ~((hx >= HS_START) && (hx < HS_END));
  assign vs_raw    = ~((vy >= VS_START) && (vy < VS_END));
  assign blank_raw = (hx < H_VIS) && (vy < V_VIS);

  vga_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL ({HS_INACTIVE, VS_INACTIVE, BLANK_INACTIVE})
  ) u_sync_delay (
    .vga_clk (vga_clk),
    .reset   (reset),
    .data    ({hs_raw, vs_raw, blank_raw}),
    .delayed ({hs, vs, blank})
  );

  assign DrawX       = hc;
  assign DrawY       = vc;
  assign frame_count = frames;
  assign line_start  = (hc == '0) & ~reset;
  assign frame_start = (hc == '0) & (vc == '0) & ~reset;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates VGA raster timing for the 640x480 display path: horizontal/vertical counters, sync pulses, display-enable and pixel coordinates. Sits directly upstream of the background/sprite renderers, which consume DrawX, DrawY and blank. A configurable delay line re-aligns hs/vs/blank with the renderers' fixed colour latency, so sync and colour leave the FPGA on the same pixel. Also provides frame/line strobes and a frame counter for sprite animation.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
PIPE_DELAY, 1, cycles hs/vs/blank lag DrawX/DrawY (0..4)

Ports:
vga_clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
DrawX  out  10  horizontal counter (pixel column, includes porches)
DrawY  out  10  vertical counter (line, includes porches)
hs  out  1  horizontal sync, active-low, delayed PIPE_DELAY
vs  out  1  vertical sync, active-low, delayed PIPE_DELAY
blank  out  1  display enable (1 = visible pixel), delayed PIPE_DELAY
line_start  out  1  one-cycle pulse when DrawX==0
frame_start  out  1  one-cycle pulse when DrawX==0 and DrawY==0
frame_count  out  8  completed-frame counter

Behaviour:
- H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Elaboration error if H_TOTAL>1024, V_TOTAL>1024 or PIPE_DELAY>4.
- Reset (sampled on vga_clk rising edge): hc=vc=0, frame_count=0, every delay stage loaded with inactive values (hs=1, vs=1, blank=0). Outputs while in reset: DrawX=0, DrawY=0, hs=1, vs=1, blank=0, line_start=0, frame_start=0.
- Counters: hc increments each cycle; at hc==H_TOTAL-1, hc->0 and vc increments; at vc==V_TOTAL-1 with hc wrap, vc->0 and frame_count increments (8-bit, 255->0). DrawX=hc, DrawY=vc (registered, no extra latency).
- Raw decode from hc/vc: hs_raw=0 when H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC; vs_raw=0 when V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC (whole lines, changes at hc==0); blank_raw=1 when hc<H_VISIBLE and vc<V_VISIBLE.
- hs/vs/blank = raw values passed through PIPE_DELAY register stages; PIPE_DELAY=0 means direct decode of registered counters. Default 1 matches renderer (negedge ROM read + posedge colour register).
- line_start = (hc==0) & ~reset; frame_start = (hc==0 & vc==0) & ~reset; both aligned with DrawX/DrawY, never delayed. First cycle after reset release therefore asserts both.
- Reset mid-frame: takes effect next edge; delay line flushed to inactive so no partial sync pulse propagates; frame_count not incremented.
- No other inputs; free-running outside reset.

Decomposition:
- Package vga_timing_pkg: default 640x480@60 timing constants, typedef coord_t (logic [9:0]), H_TOTAL/V_TOTAL derivation functions, inactive sync level constants.
- Sub-module vga_delay_line (params WIDTH, DEPTH; synchronous reset loads RESET_VAL; DEPTH=0 passthrough), instantiated once with WIDTH=3 for {hs, vs, blank}.

Test Plan:
- Reset held 5 cycles then released -> during reset DrawX=DrawY=0, hs=vs=1, blank=0; after release DrawX 0,1,2,...; line_start and frame_start high on first post-reset cycle only.
- Default params, one line -> blank high for exactly 640 consecutive cycles; hs low exactly 96 cycles, first low cycle when DrawX==657 (PIPE_DELAY=1); line_start period 800.
- Default params, full frame -> frame_start period 420000 cycles; vs low for 1600 cycles beginning when DrawY==490, DrawX==1; blank never high for DrawY>=480.
- Small params (H 8/2/2/2, V 6/1/1/1, PIPE_DELAY=0) run 256 frames -> frame_count increments on each DrawX=0,DrawY=0 wrap, reads 255 then 0; decode matches counters same cycle.
- Reset asserted at DrawX=300, DrawY=200 for 1 cycle -> next cycle DrawX=DrawY=0, frame_count=0, hs/vs/blank inactive for PIPE_DELAY cycles, no spurious sync pulse.
- PIPE_DELAY=3 sweep -> hs/vs/blank equal PIPE_DELAY=0 waveforms shifted exactly 3 cycles; DrawX/DrawY/strobes unchanged.
